// File: rtl/elevator_pkg.sv
// elevator_pkg: state encoding, direction constants and width helper shared by the elevator sequencer
package elevator_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, SETTLE, DOOR} state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that parks at zero and flags it
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk)
        if (reset) r_count <= '0;
        else if (i_load) r_count <= i_value;
        else if (r_count != '0) r_count <= r_count - W'(1);
    assign o_zero = (r_count == '0);
endmodule

// File: rtl/elevator_sequencer.sv
// elevator_sequencer: SCAN-order motion and door sequencer for one car.
// Define SEQ_DOOR_REOPEN_EN to let a new call at the current floor extend an open door.
module elevator_sequencer
    import elevator_pkg::*;
#(
    parameter int FLOORS = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES = 32,
    localparam int FW = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] i_req,
    input  logic [FW-1:0]     i_floor,
    output logic              o_car_step,
    output logic              o_car_up,
    output logic [FLOORS-1:0] o_clr,
    output logic              o_door_open,
    output logic              o_dir_up,
    output logic              o_busy
);
    localparam int TW = width_of(TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES);
    state_t r_state;
    logic r_dir;
    logic [FLOORS-1:0] r_clr;
    logic [FLOORS-1:0] w_onehot, w_below_mask;
    logic w_here, w_above, w_below, w_ahead, w_behind;
    logic w_go_door, w_go_move, w_reopen, w_load, w_zero;
    logic [TW-1:0] w_value;
    assign w_onehot = FLOORS'(1) << i_floor;
    assign w_below_mask = w_onehot - FLOORS'(1);
    assign w_here = |(i_req & w_onehot);
    assign w_below = |(i_req & w_below_mask);
    assign w_above = |(i_req & ~(w_below_mask | w_onehot));
    assign w_ahead = r_dir ? w_above : w_below;
    assign w_behind = r_dir ? w_below : w_above;
    assign w_go_door = (r_state == IDLE || r_state == SETTLE) && w_here;
    assign w_go_move = !w_here && ((r_state == IDLE && (w_ahead || w_behind)) || (r_state == SETTLE && w_ahead));
`ifdef SEQ_DOOR_REOPEN_EN
    // the latch still shows the serviced call while its clear strobe is out
    assign w_reopen = (r_state == DOOR) && !(|r_clr) && w_here;
`else
    assign w_reopen = 1'b0;
`endif
    assign w_load = w_go_door || w_go_move || w_reopen;
    assign w_value = w_go_move ? TW'(TRAVEL_CYCLES - 1) : TW'(DOOR_CYCLES - 1);
    seq_timer #(.W(TW)) u_timer (
        .clk(clk),
        .reset(reset),
        .i_load(w_load),
        .i_value(w_value),
        .o_zero(w_zero)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_dir <= DIR_UP;
            r_clr <= '0;
        end else begin
            r_clr <= (w_go_door || w_reopen) ? w_onehot : '0;
            case (r_state)
                IDLE: begin
                    if (w_go_door) r_state <= DOOR;
                    else if (w_go_move) begin
                        r_state <= MOVE;
                        if (!w_ahead) r_dir <= ~r_dir;
                    end
                end
                MOVE: if (w_zero) r_state <= SETTLE;
                SETTLE: r_state <= w_go_door ? DOOR : w_go_move ? MOVE : IDLE;
                DOOR: if (w_zero && !w_reopen) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_car_step = (r_state == MOVE) && w_zero;
    assign o_car_up = o_car_step && r_dir;
    assign o_clr = r_clr;
    assign o_door_open = (r_state == DOOR);
    assign o_dir_up = r_dir;
    assign o_busy = (r_state != IDLE);
endmodule
